// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MD_FAST_SPECIAL_EN finishes divide-by-zero and signed overflow in one cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t             state, state_next;
    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               neg;
    logic               div0;
    logic [5:0]         cnt;

    // Accept-time operand decode
    logic             signed_a, signed_b, sa, sb, b_zero, neg_in;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        signed_a = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        signed_b = op[2] ? ~op[0] : (op[1:0] == 2'b01);
        sa       = a[WIDTH-1] & signed_a;
        sb       = b[WIDTH-1] & signed_b;
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;
        b_zero   = (b == '0);
        // REM follows the dividend sign; quotient and product follow the sign mismatch
        neg_in   = (op[2] && op[1]) ? sa : (sa ^ sb);
    end

`ifdef MD_FAST_SPECIAL_EN
    logic             ovf, fast;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        ovf  = op[2] && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        fast = op[2] && (b_zero || ovf);
        if (b_zero)
            special_res = op[1] ? a : '1;
        else
            special_res = op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif

    // One radix-2 step of each algorithm; acc low half holds multiplier / quotient
    logic [WIDTH:0]     sum, shifted, diff;
    logic               ge;
    logic [2*WIDTH-1:0] mul_next, div_next, acc_next, prod;
    logic [WIDTH-1:0]   quo, rem, mul_res, div_res, final_res;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {sum, acc[WIDTH-1:1]};
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        diff     = shifted - {1'b0, opnd};
        ge       = ~diff[WIDTH];
        div_next = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], ge};
        acc_next = op_q[2] ? div_next : mul_next;

        prod     = neg ? -mul_next : mul_next;
        mul_res  = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        quo      = div_next[WIDTH-1:0];
        rem      = div_next[2*WIDTH-1:WIDTH];
        // Divide by zero yields all-ones quotient regardless of dividend sign
        if (op_q[1])
            div_res = neg ? -rem : rem;
        else if (div0)
            div_res = '1;
        else
            div_res = neg ? -quo : quo;
        final_res = op_q[2] ? div_res : mul_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MD_FAST_SPECIAL_EN
                    state_next = fast ? DONE : RUN;
`else
                    state_next = RUN;
`endif
                end
            end
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg    <= 1'b0;
            div0   <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        acc  <= {{WIDTH{1'b0}}, mag_a};
                        opnd <= mag_b;
                        neg  <= neg_in;
                        div0 <= b_zero;
                        cnt  <= '0;
`ifdef MD_FAST_SPECIAL_EN
                        if (fast) result <= special_res;
`endif
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST) result <= final_res;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign zero = (result == '0);
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver pushes expected result/latency, monitor checks on done.
module tb_mul_div_unit;
    localparam int W = 32;
`ifdef MD_FAST_SPECIAL_EN
    localparam int SL = 1;
`else
    localparam int SL = 33;
`endif

    logic         clk = 1'b0;
    logic         rst, start;
    logic [2:0]   op;
    logic [W-1:0] a, b, result;
    logic         busy, done, zero;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, id = 0;
    logic [W-1:0] exp_q[$];
    int           lat_q[$], acc_q[$], id_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int tag, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s op#%0d: got %h expected %h", nm, tag, act, req);
        end
    endtask

    // Monitor: every done pops one expectation
    logic [W-1:0] m_exp;
    int           m_lat, m_acc, m_id;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_done: got done at cycle %0d expected none", cyc);
            end else begin
                m_exp = exp_q.pop_front();
                m_lat = lat_q.pop_front();
                m_acc = acc_q.pop_front();
                m_id  = id_q.pop_front();
                chk("result", m_id, result, m_exp);
                chk("zero", m_id, W'(zero), W'(m_exp == '0));
                chk("latency", m_id, W'(cyc - m_acc + 1), W'(m_lat));
            end
        end
    end

    // Returns at a negedge with busy low, or flags a timeout
    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout: got busy=1 expected busy=0 within 200 cycles");
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] e, input int lat);
        wait_idle();
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(e);
        lat_q.push_back(lat);
        acc_q.push_back(cyc);
        id_q.push_back(id);
        id++;
        // Scramble inputs to prove operands were captured at accept
        op = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] e, input int lat);
        issue(o, x, y, e, lat);
        wait_idle();
    endtask

    int d0;
    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", -1, W'(busy), '0);
        chk("rst_done", -1, W'(done), '0);
        chk("rst_result", -1, result, '0);
        chk("rst_zero", -1, W'(zero), 1);
        rst = 1'b0;

        run(3'b000, 7, 6, 42, 33);
        run(3'b011, 7, 6, 0, 33);
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run(3'b100, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 33);
        run(3'b110, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 33);
        run(3'b101, 32'hFFFF_FFF9, 2, 32'h7FFF_FFFC, 33);
        run(3'b100, 32'h1234, 0, 32'hFFFF_FFFF, SL);
        run(3'b111, 32'h1234, 0, 32'h0000_1234, SL);
        run(3'b110, 32'hFFFF_FFF9, 0, 32'hFFFF_FFF9, SL);
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SL);
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SL);
        run(3'b111, 100, 7, 2, 33);

        // start pulsed while busy must be ignored; result holds the previous value meanwhile
        issue(3'b000, 100, 3, 300, 33);
        repeat (4) @(negedge clk);
        op = 3'b100; a = 9; b = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold_result", id - 1, result, 32'h2);
        wait_idle();
        repeat (40) @(negedge clk);

        // Reset mid-operation at RUN step 10
        wait_idle();
        op = 3'b000; a = 5; b = 5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", -1, W'(busy), '0);
        chk("midrst_result", -1, result, '0);
        chk("midrst_zero", -1, W'(zero), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", -1, W'(done_cnt), W'(d0));

        run(3'b001, 32'hFFFF_FFFE, 3, 32'hFFFF_FFFF, 33);
        run(3'b000, 32'hFFFF_FFFE, 3, 32'hFFFF_FFFA, 33);
        run(3'b100, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);

        repeat (5) @(negedge clk);
        chk("queue_empty", -1, W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multi-cycle multiply/divide unit implementing the RV32M operation set. It sits beside the single-cycle ALU in the execute stage and takes the long-latency operations the ALU does not cover. The execute stage issues an operation with a start/busy/done handshake and stalls until done. Like the ALU, it presents a `result` and a `zero` flag, but it holds both until the next accepted operation.

## Interface
- `WIDTH`, 32: operand and result width. Verification covers 32 only.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  operation request. Sampled only when `busy`=0.
- `op`  in  3  RV32M funct3 code:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  WIDTH  rs1 operand (multiplicand or dividend).
- `b`  in  WIDTH  rs2 operand (multiplier or divisor).
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  single-cycle pulse; `result` is valid when it is high.
- `result`  out  WIDTH  registered result. Held from DONE until the next accept.
- `zero`  out  1  (`result` == 0).

## Operation
- States:
  - IDLE: accepts work when `start`=1. Latches `op` and the operand magnitudes, records the sign fix-ups, clears the 6-bit iteration counter, and goes to RUN.
  - RUN: performs one radix-2 step per cycle. After WIDTH steps it writes `result` and goes to DONE.
  - DONE: asserts `done` for exactly one cycle, then returns to IDLE.
- `start` while `busy`=1 is ignored. It is not queued.
- Operands and `op` are captured at accept. Later input changes have no effect on the operation in flight.
- Multiply:
  - Unsigned shift-add into a 2·WIDTH accumulator.
  - MUL returns the low half.
  - MULH (signed×signed), MULHSU (signed×unsigned) and MULHU return the high half.
  - Signed operands are converted to magnitudes. The 2·WIDTH product is negated when the operand signs differ.
- Divide:
  - Restoring shift-subtract on magnitudes.
  - The quotient is negated when the operand signs differ (DIV only).
  - The remainder takes the sign of the dividend (REM only).
- Special cases:
  - Divide by zero: quotient = all ones, remainder = `a`.
  - Signed overflow (`a`=0x80000000, `b`=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
  - Without the configuration macro, special cases take the full latency.
- Reset values, and the state when `rst` is asserted mid-operation:
  - State IDLE, `busy` 0, `done` 0, `result` 0, `zero` 1.
  - Any in-flight operation is discarded with no `done`.

## Timing
- Accept edge = edge E (IDLE, `start`=1).
- RUN steps occur on edges E+1 … E+WIDTH. `result` is written at E+WIDTH.
- `done`=1 during the cycle after E+WIDTH. Latency from accept to `done` is WIDTH+1 cycles (33).
- `busy` rises after E and falls after E+WIDTH+1.
- Back-to-back issue: the earliest next accept edge is E+WIDTH+2. `start` held high continuously yields one operation every WIDTH+2 cycles.
- `result` and `zero` are stable from the `done` cycle until the edge after the next accept edge. They are first updated at E'+WIDTH of the following operation.

## Configuration
- `MD_FAST_SPECIAL_EN` defined:
  - Division by zero and signed overflow are detected at accept. The unit goes IDLE→DONE directly, with `result` written at edge E.
  - `done` is high the cycle after E, so latency is 1 cycle.
  - All other operations are unchanged.
- `MD_FAST_SPECIAL_EN` undefined: every operation, including special cases, takes WIDTH+1 cycles.

## Test plan
- MUL a=7, b=6 → `done` exactly 33 cycles after accept, `result`=42, `zero`=0. MULHU on the same operands → 0, `zero`=1.
- MULH a=0xFFFFFFFF (−1), b=0xFFFFFFFF → `result`=0. MULHSU on the same operands → 0xFFFFFFFF. MULHU on the same operands → 0xFFFFFFFE.
- Signed divide, a=−7 (0xFFFFFFF9), b=2:
  - DIV → 0xFFFFFFFD (−3).
  - REM → 0xFFFFFFFF (−1).
  - DIVU → 0x7FFFFFFC.
- Division by zero, a=0x1234, b=0:
  - DIV → 0xFFFFFFFF.
  - REMU → 0x1234.
  - Latency is 33 cycles without the macro and 1 cycle with it.
- Signed overflow, DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
- Handshake checks:
  - Pulse `start` with new operands while `busy` → no effect on `result` and no extra `done`.
  - Assert `rst` at RUN step 10 → `busy`=0, `done` never asserted, `result`=0, `zero`=1.
  - A fresh op accepted after reset completes correctly.
